// File: rtl/pacman_move_ctrl.sv
// Pac-Man movement controller: proposes the next cell to the collision lookup,
// waits for the result, then commits or rejects the move (with one cornering retry).
// Also keeps the buffered player heading, tunnel wrap-around and the saturating score.
module pacman_move_ctrl #(
   parameter int unsigned START_X     = 20,
   parameter int unsigned START_Y     = 21,
   parameter int unsigned GRID_W      = 40,
   parameter int unsigned GRID_H      = 30,
   parameter int unsigned LOOKUP_WAIT = 4,
   parameter int unsigned DOT_PTS     = 10,
   parameter int unsigned PILL_PTS    = 50
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [3:0]  dir_req,
   input  logic        move_tick,
   input  logic [3:0]  collision_type,
   output logic [5:0]  next_pacman_x,
   output logic [4:0]  next_pacman_y,
   output logic        colli_clr,
   output logic [5:0]  pacman_x,
   output logic [4:0]  pacman_y,
   output logic [1:0]  pacman_dir,
   output logic        moved,
   output logic        dot_eaten,
   output logic        pill_eaten,
   output logic [15:0] score
);

   localparam logic [1:0]  DirUp    = 2'b00;
   localparam logic [1:0]  DirDown  = 2'b01;
   localparam logic [1:0]  DirLeft  = 2'b10;
   localparam logic [1:0]  DirRight = 2'b11;

   localparam logic [5:0]  XMax     = 6'(GRID_W - 1);
   localparam logic [4:0]  YMax     = 5'(GRID_H - 1);
   localparam logic [5:0]  XStart   = 6'(START_X);
   localparam logic [4:0]  YStart   = 5'(START_Y);
   localparam logic [7:0]  WaitInit = 8'(LOOKUP_WAIT);
   localparam logic [15:0] DotPts   = 16'(DOT_PTS);
   localparam logic [15:0] PillPts  = 16'(PILL_PTS);

   localparam logic [3:0]  CtWall   = 4'b0001;
   localparam logic [3:0]  CtDot    = 4'b0010;
   localparam logic [3:0]  CtPill   = 4'b0011;

   typedef enum logic [1:0] {StIdle, StProbe, StDecide, StClear} state_e;

   // With a one-cycle lookup the probe is sampled on the very next cycle.
   localparam state_e FirstSt = (LOOKUP_WAIT <= 1) ? StDecide : StProbe;

   state_e      state_q, state_d;
   logic [5:0]  pos_x_q, pos_x_d;
   logic [4:0]  pos_y_q, pos_y_d;
   logic [1:0]  cur_dir_q, cur_dir_d;
   logic [1:0]  buf_dir_q, buf_dir_d;
   logic        tick_q;
   logic        pend_q, pend_d;
   logic [5:0]  cand_x_q, cand_x_d;
   logic [4:0]  cand_y_q, cand_y_d;
   logic [1:0]  tried_q, tried_d;
   logic        retried_q, retried_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [5:0]  next_x_q, next_x_d;
   logic [4:0]  next_y_q, next_y_d;
   logic        clr_q, clr_d;
   logic        moved_q, moved_d;
   logic        dot_q, dot_d;
   logic        pill_q, pill_d;
   logic [15:0] score_q, score_d;

   logic        start;
   logic        is_wall;
   logic        retry;
   logic [10:0] nb_buf;
   logic [10:0] nb_cur;
   logic [15:0] pts;
   logic [16:0] sum;

   // Neighbouring cell in the given heading, wrapping at the grid edges; returns {x, y}.
   function automatic logic [10:0] neighbour(input logic [5:0] x, input logic [4:0] y,
                                             input logic [1:0] d);
      logic [5:0] nx;
      logic [4:0] ny;
      nx = x;
      ny = y;
      case (d)
         DirUp:    ny = (y == 5'd0) ? YMax : y - 5'd1;
         DirDown:  ny = (y == YMax) ? 5'd0 : y + 5'd1;
         DirLeft:  nx = (x == 6'd0) ? XMax : x - 6'd1;
         DirRight: nx = (x == XMax) ? 6'd0 : x + 6'd1;
         default:  nx = x;
      endcase
      return {nx, ny};
   endfunction

   assign start   = tick_q || pend_q;
   assign is_wall = (collision_type == CtWall);
   // Cornering: only the buffered heading may fall back to the current one, and only once.
   assign retry   = is_wall && !retried_q && (tried_q == buf_dir_q) && (buf_dir_q != cur_dir_q);
   assign nb_buf  = neighbour(pos_x_q, pos_y_q, buf_dir_q);
   assign nb_cur  = neighbour(pos_x_q, pos_y_q, cur_dir_q);
   assign pts     = (collision_type == CtDot)  ? DotPts :
                    (collision_type == CtPill) ? PillPts : 16'd0;
   assign sum     = {1'b0, score_q} + {1'b0, pts};

   // State register.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (start) state_d = FirstSt;
         StProbe:  if (cnt_q <= 8'd2) state_d = StDecide;
         StDecide: state_d = retry ? FirstSt : StClear;
         StClear:  state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Datapath and registered-output next values.
   always_comb begin
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      cur_dir_d = cur_dir_q;
      buf_dir_d = buf_dir_q;
      pend_d    = pend_q;
      cand_x_d  = cand_x_q;
      cand_y_d  = cand_y_q;
      tried_d   = tried_q;
      retried_d = retried_q;
      cnt_d     = cnt_q;
      clr_d     = 1'b0;
      moved_d   = 1'b0;
      dot_d     = 1'b0;
      pill_d    = 1'b0;
      score_d   = score_q;

      case (dir_req)
         4'b1000: buf_dir_d = DirUp;
         4'b0100: buf_dir_d = DirDown;
         4'b0010: buf_dir_d = DirLeft;
         4'b0001: buf_dir_d = DirRight;
         default: buf_dir_d = buf_dir_q;
      endcase

      // One-deep tick buffer while a move is in flight.
      if (tick_q && (state_q != StIdle)) pend_d = 1'b1;

      case (state_q)
         StIdle: begin
            if (start) begin
               {cand_x_d, cand_y_d} = nb_buf;
               tried_d   = buf_dir_q;
               retried_d = 1'b0;
               cnt_d     = WaitInit;
               pend_d    = 1'b0;
            end
         end
         StProbe: begin
            cnt_d = cnt_q - 8'd1;
         end
         StDecide: begin
            if (!is_wall) begin
               pos_x_d   = cand_x_q;
               pos_y_d   = cand_y_q;
               cur_dir_d = tried_q;
               moved_d   = 1'b1;
               dot_d     = (collision_type == CtDot);
               pill_d    = (collision_type == CtPill);
               score_d   = sum[16] ? 16'hFFFF : sum[15:0];
               clr_d     = 1'b1;
            end else if (retry) begin
               {cand_x_d, cand_y_d} = nb_cur;
               tried_d   = cur_dir_q;
               retried_d = 1'b1;
               cnt_d     = WaitInit;
            end else begin
               clr_d = 1'b1;
            end
         end
         default: begin
         end
      endcase

      if ((state_d == StProbe) || (state_d == StDecide)) begin
         next_x_d = cand_x_d;
         next_y_d = cand_y_d;
      end else begin
         next_x_d = pos_x_d;
         next_y_d = pos_y_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         pos_x_q   <= XStart;
         pos_y_q   <= YStart;
         cur_dir_q <= DirLeft;
         buf_dir_q <= DirLeft;
         tick_q    <= 1'b0;
         pend_q    <= 1'b0;
         cand_x_q  <= XStart;
         cand_y_q  <= YStart;
         tried_q   <= DirLeft;
         retried_q <= 1'b0;
         cnt_q     <= 8'd0;
         next_x_q  <= XStart;
         next_y_q  <= YStart;
         clr_q     <= 1'b0;
         moved_q   <= 1'b0;
         dot_q     <= 1'b0;
         pill_q    <= 1'b0;
         score_q   <= 16'd0;
      end else begin
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         cur_dir_q <= cur_dir_d;
         buf_dir_q <= buf_dir_d;
         tick_q    <= move_tick;
         pend_q    <= pend_d;
         cand_x_q  <= cand_x_d;
         cand_y_q  <= cand_y_d;
         tried_q   <= tried_d;
         retried_q <= retried_d;
         cnt_q     <= cnt_d;
         next_x_q  <= next_x_d;
         next_y_q  <= next_y_d;
         clr_q     <= clr_d;
         moved_q   <= moved_d;
         dot_q     <= dot_d;
         pill_q    <= pill_d;
         score_q   <= score_d;
      end
   end

   assign next_pacman_x = next_x_q;
   assign next_pacman_y = next_y_q;
   assign colli_clr     = clr_q;
   assign pacman_x      = pos_x_q;
   assign pacman_y      = pos_y_q;
   assign pacman_dir    = cur_dir_q;
   assign moved         = moved_q;
   assign dot_eaten     = dot_q;
   assign pill_eaten    = pill_q;
   assign score         = score_q;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Scoreboard bench for pacman_move_ctrl: each tick pushes its expected decision,
// a monitor pops and compares on every colli_clr pulse.
module tb_pacman_move_ctrl;

   localparam int LW = 4;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic [3:0]  dir_req;
   logic        move_tick;
   logic [3:0]  collision_type;
   logic [5:0]  next_pacman_x;
   logic [4:0]  next_pacman_y;
   logic        colli_clr;
   logic [5:0]  pacman_x;
   logic [4:0]  pacman_y;
   logic [1:0]  pacman_dir;
   logic        moved;
   logic        dot_eaten;
   logic        pill_eaten;
   logic [15:0] score;

   always #5 CLOCK_50 = ~CLOCK_50;

   pacman_move_ctrl #(
      .START_X     (20),
      .START_Y     (21),
      .GRID_W      (40),
      .GRID_H      (30),
      .LOOKUP_WAIT (LW),
      .DOT_PTS     (10),
      .PILL_PTS    (50)
   ) dut (
      .CLOCK_50       (CLOCK_50),
      .reset          (reset),
      .dir_req        (dir_req),
      .move_tick      (move_tick),
      .collision_type (collision_type),
      .next_pacman_x  (next_pacman_x),
      .next_pacman_y  (next_pacman_y),
      .colli_clr      (colli_clr),
      .pacman_x       (pacman_x),
      .pacman_y       (pacman_y),
      .pacman_dir     (pacman_dir),
      .moved          (moved),
      .dot_eaten      (dot_eaten),
      .pill_eaten     (pill_eaten),
      .score          (score)
   );

   // Maze model answering the probed cell.
   logic [3:0] cmap [0:39][0:29];
   assign collision_type = (next_pacman_x < 6'd40 && next_pacman_y < 5'd30) ?
                           cmap[next_pacman_x][next_pacman_y] : 4'h0;

   typedef struct {
      int x, y, dir, mv, dot, pill, score, probes, cyc;
   } exp_t;

   exp_t q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;
   int   probe_cnt  = 0;
   bit   mon_en     = 1'b0;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares each decision and counts cycles spent probing a neighbour cell.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLOCK_50);
         if (reset !== 1'b1) begin
            probe_cnt = 0;
         end else if (mon_en) begin
            if (colli_clr === 1'b1) begin
               if (q.size() == 0) begin
                  chk("unexpected_colli_clr", 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("pos_x", int'(pacman_x), e.x);
                  chk("pos_y", int'(pacman_y), e.y);
                  chk("dir", int'(pacman_dir), e.dir);
                  chk("moved", int'(moved), e.mv);
                  chk("dot_eaten", int'(dot_eaten), e.dot);
                  chk("pill_eaten", int'(pill_eaten), e.pill);
                  chk("score", int'(score), e.score);
                  chk("probe_cycles", probe_cnt, e.probes);
                  chk("clear_cycle", cyc, e.cyc);
                  chk("next_eq_pos", int'({next_pacman_x, next_pacman_y}),
                      int'({pacman_x, pacman_y}));
               end
               probe_cnt = 0;
            end else begin
               chk("stray_pulse", int'({moved, dot_eaten, pill_eaten}), 0);
               if ({next_pacman_x, next_pacman_y} != {pacman_x, pacman_y}) probe_cnt++;
            end
         end
      end
   end

   task automatic tick(output int n);
      @(negedge CLOCK_50);
      move_tick = 1'b1;
      n = cyc + 1;
      @(negedge CLOCK_50);
      move_tick = 1'b0;
   endtask

   task automatic push(input int x, input int y, input int dir, input int mv, input int dot,
                       input int pill, input int sc, input int probes, input int clr_cyc);
      exp_t e;
      e.x = x; e.y = y; e.dir = dir; e.mv = mv; e.dot = dot; e.pill = pill;
      e.score = sc; e.probes = probes; e.cyc = clr_cyc;
      q.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && q.size() != 0; i++) begin
         @(negedge CLOCK_50);
         #1;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   // One tick; nprobes is the number of cells probed (2 when cornering retries).
   task automatic move(input int x, input int y, input int dir, input int mv, input int dot,
                       input int pill, input int sc, input int nprobes);
      int n;
      tick(n);
      push(x, y, dir, mv, dot, pill, sc, LW * nprobes, n + LW * nprobes + 1);
      drain();
   endtask

   task automatic set_dir(input logic [3:0] d);
      @(negedge CLOCK_50);
      dir_req = d;
      @(negedge CLOCK_50);
      dir_req = 4'b0000;
   endtask

   task automatic chk_rst();
      chk("rst_pos_x", int'(pacman_x), 20);
      chk("rst_pos_y", int'(pacman_y), 21);
      chk("rst_dir", int'(pacman_dir), 2);
      chk("rst_score", int'(score), 0);
      chk("rst_pulses", int'({moved, dot_eaten, pill_eaten, colli_clr}), 0);
      chk("rst_next_x", int'(next_pacman_x), 20);
      chk("rst_next_y", int'(next_pacman_y), 21);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n1, n2, n3, s;
      reset     = 1'b0;
      move_tick = 1'b0;
      dir_req   = 4'b0000;
      for (int x = 0; x < 40; x++)
         for (int y = 0; y < 30; y++)
            cmap[x][y] = 4'h0;

      repeat (2) @(negedge CLOCK_50);
      reset = 1'b1;
      chk_rst();
      mon_en = 1'b1;

      // Empty move right, then a dot and a pill.
      set_dir(4'b0001);
      move(21, 21, 3, 1, 0, 0, 0, 1);
      cmap[22][21] = 4'b0010;
      move(22, 21, 3, 1, 1, 0, 10, 1);
      cmap[23][21] = 4'b0011;
      move(23, 21, 3, 1, 0, 1, 60, 1);

      // Back to start; cornering: up is a wall, fall back to left.
      @(negedge CLOCK_50);
      reset = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      reset = 1'b1;
      chk_rst();
      set_dir(4'b1000);
      cmap[20][20] = 4'b0001;
      move(19, 21, 2, 1, 0, 0, 0, 2);

      // Wall straight ahead with no alternate heading; multi-hot request ignored.
      set_dir(4'b0010);
      cmap[18][21] = 4'b0001;
      move(19, 21, 2, 0, 0, 0, 0, 1);
      set_dir(4'b0101);
      move(19, 21, 2, 0, 0, 0, 0, 1);

      // Walk left to column 0.
      cmap[18][21] = 4'h0;
      for (int x = 18; x >= 0; x--) move(x, 21, 2, 1, 0, 0, 0, 1);

      // Wrap 0 -> 39 with a pending tick mid-probe and a third tick that is dropped.
      tick(n1);
      push(39, 21, 2, 1, 0, 0, 0, LW, n1 + LW + 1);
      push(38, 21, 2, 1, 0, 0, 0, LW, n1 + 2 * LW + 3);
      @(negedge CLOCK_50);
      tick(n2);
      tick(n3);
      drain();
      repeat (15) @(negedge CLOCK_50);

      // Reset in the middle of a probe.
      tick(n1);
      @(negedge CLOCK_50);
      reset = 1'b0;
      @(negedge CLOCK_50);
      reset = 1'b1;
      chk_rst();
      repeat (12) @(negedge CLOCK_50);
      set_dir(4'b0001);
      move(21, 21, 3, 1, 0, 0, 0, 1);

      // Pills along the whole row, wrapping right, until the score saturates.
      for (int x = 0; x < 40; x++) cmap[x][21] = 4'b0011;
      for (int k = 1; k <= 1315; k++) begin
         s = (50 * k > 65535) ? 65535 : 50 * k;
         move((21 + k) % 40, 21, 3, 1, 0, 1, s, 1);
      end

      repeat (5) @(negedge CLOCK_50);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pacman_move_ctrl.md
# pacman_move_ctrl

Movement controller directly upstream of `collision_detect`. On each game move tick it proposes Pac-Man's next grid cell on `next_pacman_x`/`next_pacman_y` and waits for the lookup to settle. It then samples `collision_type` and either commits the move or rejects it, and pulses `colli_clr` once per decision. It also holds the buffered player direction (cornering), applies tunnel wrap-around, and keeps the score for dots and pills.

## Interface
Parameters:
- `START_X`, 20: reset column (0..GRID_W-1).
- `START_Y`, 21: reset row (0..GRID_H-1).
- `GRID_W`, 40: columns per row (160-bit map word / 4 bits per cell).
- `GRID_H`, 30: rows.
- `LOOKUP_WAIT`, 4: cycles a probe address is held before `collision_type` is sampled (>=1).
- `DOT_PTS`, 10: score per dot.
- `PILL_PTS`, 50: score per pill.

Ports:
- `CLOCK_50`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `dir_req`  in  4  player request, one-hot {up,down,left,right} = bits [3:0]; any other value = no request.
- `move_tick`  in  1  single-cycle pulse; one move attempt per pulse.
- `collision_type`  in  4  lookup result for the proposed cell: 0000 empty, 0001 wall, 0010 dot, 0011 pill, others treated as empty.
- `next_pacman_x`  out  6  cell being probed; equals `pacman_x` outside PROBE/DECIDE.
- `next_pacman_y`  out  5  as above, row.
- `colli_clr`  out  1  one-cycle pulse after every decision.
- `pacman_x`  out  6  committed column.
- `pacman_y`  out  5  committed row.
- `pacman_dir`  out  2  committed heading: 00 up, 01 down, 10 left, 11 right.
- `moved`  out  1  one-cycle pulse when a move commits.
- `dot_eaten`  out  1  one-cycle pulse, coincident with `moved`, when the target was a dot.
- `pill_eaten`  out  1  one-cycle pulse, coincident with `moved`, when the target was a pill.
- `score`  out  16  accumulated points, saturating.

## Operation
- Registers: current heading `cur_dir`, buffered heading `buf_dir`, pending-tick flag, probe candidate, wait counter, FSM state.
- `buf_dir` loads on any cycle in which `dir_req` is exactly one-hot. Zero and multi-hot values leave it unchanged.
- Neighbour computation: up y-1, down y+1, left x-1, right x+1. Wrap-around: x 0 left → GRID_W-1, x GRID_W-1 right → 0; y 0 up → GRID_H-1, y GRID_H-1 down → 0.
- FSM states: IDLE, PROBE, DECIDE, CLEAR.
  - IDLE: on `move_tick` or pending flag, set candidate = neighbour(pos, `buf_dir`), tried_dir = `buf_dir`, counter = LOOKUP_WAIT, clear pending flag, go to PROBE.
  - PROBE: drive the candidate on `next_pacman_*`; decrement the counter; go to DECIDE when it reaches 1.
  - DECIDE: sample `collision_type`.
    - Non-wall: commit pos = candidate, `cur_dir` = tried_dir. Pulse `moved`, plus `dot_eaten`/`pill_eaten` as applicable. Add DOT_PTS or PILL_PTS to `score`. Go to CLEAR.
    - Wall with tried_dir = `buf_dir` ≠ `cur_dir`: retry. Candidate = neighbour(pos, `cur_dir`), tried_dir = `cur_dir`, counter reloaded, go to PROBE.
    - Wall otherwise: no move, no score, go to CLEAR.
  - CLEAR: assert `colli_clr` for this cycle only; `next_pacman_*` = committed pos; go to IDLE.
- At most one retry per tick; at most one committed move per tick.
- `move_tick` outside IDLE sets the pending flag (one deep). Further ticks before it is consumed are dropped.
- `score` saturates at 16'hFFFF.
- Reset (`reset` = 0, any state, including mid-probe) forces:
  - pos = (START_X, START_Y);
  - `cur_dir` = `buf_dir` = 10 (left);
  - `score` = 0, pending flag = 0, state = IDLE;
  - `next_pacman_*` = start position;
  - `moved`, `dot_eaten`, `pill_eaten`, `colli_clr` = 0.
- Reset has priority over every other input.

## Timing
- Tick sampled in IDLE at edge T:
  - PROBE occupies T+1 .. T+LOOKUP_WAIT−1.
  - DECIDE occupies cycle T+LOOKUP_WAIT.
  - `pacman_*`, `moved`, `score` update at edge T+LOOKUP_WAIT+1, together with `colli_clr` = 1 (CLEAR).
  - Back in IDLE at T+LOOKUP_WAIT+2.
- A retry adds LOOKUP_WAIT cycles.
- `next_pacman_*` is stable for the full PROBE+DECIDE window, so the two-cycle hold/compute loop of `collision_detect` sees each probe at least once.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles, then release → pos (20,21), dir 10, score 0, all pulses 0, `next_pacman` = (20,21).
- **Empty move:** `dir_req`=0001 (right), tick, `collision_type`=0000 → after LOOKUP_WAIT+1 cycles pos (21,21), dir 11, `moved` 1 cycle, `colli_clr` 1 cycle, score 0.
- **Dot, then pill:** tick with 0010 → score 10, `dot_eaten` pulse. Tick with 0011 → score 60, `pill_eaten` pulse.
- **Cornering:** `cur_dir` left, `buf_dir` up, model returns 0001 for (20,20) and 0000 for (19,21) → two probes seen, pos (19,21), dir stays 10, `buf_dir` stays up.
- **Wall, no retry:** `buf_dir` = `cur_dir` = left, `collision_type`=0001 → pos unchanged, `moved` 0, `colli_clr` pulses once.
- **Wrap and pending tick:** pos (0,21) heading left, empty → pos (39,21). Second tick issued mid-PROBE → second move starts on the cycle after CLEAR; a third tick in the same window is dropped. `reset`=0 mid-PROBE → state IDLE, pos (20,21).
